// File: rtl/gray_counter_arbiter.sv
// Round-robin arbiter sharing one Gray/binary counter between two requesters.
// One operation in flight at a time; read results are returned from a holding register.
module gray_counter_arbiter #(
  parameter int width = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             req0__ENA,
  input  logic [2:0]       req0_op,
  input  logic [width-1:0] req0_v,
  output logic             req0__RDY,
  output logic             rsp0__ENA,
  output logic [width-1:0] rsp0_v,
  input  logic             rsp0__RDY,
  input  logic             req1__ENA,
  input  logic [2:0]       req1_op,
  input  logic [width-1:0] req1_v,
  output logic             req1__RDY,
  output logic             rsp1__ENA,
  output logic [width-1:0] rsp1_v,
  input  logic             rsp1__RDY,
  output logic             increment__ENA,
  input  logic             increment__RDY,
  output logic             decrement__ENA,
  input  logic             decrement__RDY,
  input  logic [width-1:0] readGray,
  input  logic             readGray__RDY,
  output logic             writeGray__ENA,
  output logic [width-1:0] writeGray_v,
  input  logic             writeGray__RDY,
  input  logic [width-1:0] readBin,
  input  logic             readBin__RDY,
  output logic             writeBin__ENA,
  output logic [width-1:0] writeBin_v,
  input  logic             writeBin__RDY,
  output logic             illegal_op
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  localparam logic [2:0] OP_INC = 3'd0;
  localparam logic [2:0] OP_DEC = 3'd1;
  localparam logic [2:0] OP_RDG = 3'd2;
  localparam logic [2:0] OP_WRG = 3'd3;
  localparam logic [2:0] OP_RDB = 3'd4;
  localparam logic [2:0] OP_WRB = 3'd5;

  state_t           r_state, w_next;
  logic [2:0]       r_op;
  logic [width-1:0] r_v;
  logic             r_owner;
  logic             r_last;
  logic [width-1:0] r_rsp;

  logic [1:0]       w_gnt;
  logic             w_fire, w_sel, w_sel_illegal;
  logic [2:0]       w_sel_op;
  logic [width-1:0] w_sel_v;
  logic             w_exec, w_resp, w_act_done, w_rd_done, w_rsp_done;

  // Contested grant goes to whoever did not win last time.
  always_comb begin
    w_gnt = 2'b00;
    if (r_state == S_IDLE && !RST) begin
      w_gnt[0] = req0__ENA && (!req1__ENA || r_last);
      w_gnt[1] = req1__ENA && (!req0__ENA || !r_last);
    end
  end

  assign req0__RDY     = w_gnt[0];
  assign req1__RDY     = w_gnt[1];
  assign w_fire        = |w_gnt;
  assign w_sel         = w_gnt[1];
  assign w_sel_op      = w_sel ? req1_op : req0_op;
  assign w_sel_v       = w_sel ? req1_v  : req0_v;
  assign w_sel_illegal = (w_sel_op[2:1] == 2'b11);

  assign w_exec = (r_state == S_EXEC) && !RST;
  assign w_resp = (r_state == S_RESP) && !RST;

  assign increment__ENA = w_exec && (r_op == OP_INC) && increment__RDY;
  assign decrement__ENA = w_exec && (r_op == OP_DEC) && decrement__RDY;
  assign writeGray__ENA = w_exec && (r_op == OP_WRG) && writeGray__RDY;
  assign writeBin__ENA  = w_exec && (r_op == OP_WRB) && writeBin__RDY;
  assign writeGray_v    = (r_state == S_EXEC) ? r_v : '0;
  assign writeBin_v     = (r_state == S_EXEC) ? r_v : '0;

  assign w_act_done = increment__ENA || decrement__ENA || writeGray__ENA || writeBin__ENA;
  assign w_rd_done  = w_exec && (((r_op == OP_RDG) && readGray__RDY) ||
                                 ((r_op == OP_RDB) && readBin__RDY));

  assign rsp0__ENA  = w_resp && !r_owner;
  assign rsp1__ENA  = w_resp &&  r_owner;
  assign rsp0_v     = rsp0__ENA ? r_rsp : '0;
  assign rsp1_v     = rsp1__ENA ? r_rsp : '0;
  assign w_rsp_done = (rsp0__ENA && rsp0__RDY) || (rsp1__ENA && rsp1__RDY);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_fire && !w_sel_illegal) w_next = S_EXEC;
      S_EXEC: begin
        if (w_rd_done)       w_next = S_RESP;
        else if (w_act_done) w_next = S_IDLE;
      end
      S_RESP: if (w_rsp_done) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_op       <= '0;
      r_v        <= '0;
      r_owner    <= 1'b0;
      r_last     <= 1'b1;
      r_rsp      <= '0;
      illegal_op <= 1'b0;
    end else begin
      if (w_fire) begin
        r_op    <= w_sel_op;
        r_v     <= w_sel_v;
        r_owner <= w_sel;
        r_last  <= w_sel;
        if (w_sel_illegal) illegal_op <= 1'b1;
      end
      if (w_rd_done) r_rsp <= (r_op == OP_RDG) ? readGray : readBin;
    end
  end

endmodule

// File: doc/gray_counter_arbiter.md
Name: gray_counter_arbiter

Overview:
- Shares one GrayCounter instance (client side of GrayCounterIfc) between two requesters.
- Each requester issues one operation at a time: increment, decrement, read/write Gray, read/write binary.
- Round-robin grant, single outstanding operation, registered response path for reads.
- Sits between the per-requester P2M-decoded method ports and the counter instance inside l_top-level wrappers.

Parameters:
width, 4, counter width in bits; sizes all data ports.

Ports:
CLK  input  1  clock
RST  input  1  reset; synchronous, active-high
req0__ENA  input  1  requester 0 issues an operation
req0$op  input  3  opcode: 0 inc, 1 dec, 2 readGray, 3 writeGray, 4 readBin, 5 writeBin, 6-7 illegal
req0$v  input  width  write data; ignored for other opcodes
req0__RDY  output  1  arbiter accepts from requester 0 this cycle
rsp0__ENA  output  1  read result valid for requester 0
rsp0$v  output  width  read result
rsp0__RDY  input  1  requester 0 takes the result
req1__ENA, req1$op, req1$v, req1__RDY, rsp1__ENA, rsp1$v, rsp1__RDY: same as requester 0, for requester 1
increment__ENA  output  1  counter increment
increment__RDY  input  1  counter ready for increment
decrement__ENA  output  1  counter decrement
decrement__RDY  input  1  counter ready for decrement
readGray  input  width  counter Gray value
readGray__RDY  input  1  Gray value valid
writeGray__ENA  output  1  counter Gray write
writeGray$v  output  width  Gray write data
writeGray__RDY  input  1  counter ready for Gray write
readBin  input  width  counter binary value
readBin__RDY  input  1  binary value valid
writeBin__ENA  output  1  counter binary write
writeBin$v  output  width  binary write data
writeBin__RDY  input  1  counter ready for binary write
illegal_op  output  1  sticky flag: an illegal opcode was accepted

Behaviour:
- States: IDLE, EXEC, RESP. Registers:
  - op_q[2:0], v_q[width-1:0], owner_q (requester index)
  - last_q (last granted requester)
  - rsp_q[width-1:0]
  - illegal_op
- Reset: state=IDLE, last_q=1 (requester 0 wins first), illegal_op=0. All __ENA outputs 0, rsp$v 0, req__RDY deasserted during the reset cycle.
- IDLE grant:
  - If only one reqN__ENA is high, reqN__RDY=1 for that requester.
  - If both are high, grant goes to the requester != last_q.
  - The loser's RDY stays 0.
  - reqN__ENA asserted while reqN__RDY=0 is ignored and not latched.
- On a fire (ENA&&RDY) at cycle t:
  - op_q, v_q and owner_q are loaded; last_q=N.
  - state=EXEC at t+1.
- Illegal opcode (6, 7):
  - Set illegal_op. Clear it only on RST.
  - Go to IDLE next cycle; no counter method fired, no response.
- EXEC behaviour:
  - Exactly one counter action is enabled, combinationally gated by its RDY: increment__ENA = (op_q==0)&&increment__RDY; decrement, writeGray, writeBin likewise.
  - writeGray$v and writeBin$v are driven from v_q; they are 0 outside EXEC.
  - Action ops: when the gated ENA fires, go to IDLE at the next cycle. Otherwise stay in EXEC; no timeout.
  - Read ops (2, 4): when the matching __RDY is high, capture readGray or readBin into rsp_q and go to RESP. Otherwise stay in EXEC.
- RESP behaviour:
  - rspN__ENA=1 for owner_q only; rspN$v=rsp_q. The other requester's rsp$v=0.
  - Held stable until rspN__RDY=1, then go to IDLE next cycle.
- Latency:
  - Action op: accepted at t, counter method fires at t+1 if ready, new request accepted at t+2 earliest.
  - Read op: accepted at t, value sampled at t+1, rsp__ENA at t+2.
- At most one counter __ENA is high in any cycle. No counter ENA is asserted in IDLE or RESP.
- No new grant while in EXEC or RESP; both req__RDY=0.
- RST in EXEC or RESP aborts the operation: no further counter ENA, pending response discarded, last_q=1.

Test Plan:
- Single requester 0 issues inc ×3, then readBin (width=4, counter from 0) -> three increment__ENA pulses, one per op, rsp0$v=4'd3; rsp0__ENA first high 2 cycles after read accept.
- Both requesters assert inc every cycle for 6 grants -> grant order 0,1,0,1,0,1; increment__ENA never high on consecutive operations without an intervening IDLE cycle.
- req1 writeBin v=4'hA, then req0 readGray -> writeBin$v=4'hA when writeBin__ENA is high; rsp0$v=4'hF (Gray of 0xA).
- Hold decrement__RDY=0 for 5 cycles during a dec op -> state stays EXEC, both req__RDY=0; a single decrement__ENA pulse when RDY rises, then IDLE.
- Read result with rsp0__RDY=0 for 4 cycles -> rsp0__ENA and rsp0$v stable, req1 blocked; completes the cycle after rsp0__RDY=1.
- Opcode 7 accepted, then RST mid-EXEC of a writeGray -> illegal_op=1 until RST, no counter ENA for op 7. After RST all ENA=0, illegal_op=0, and the next contested grant goes to requester 0.
